// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit CPU: steps T-states, decodes the opcode and drives
// the bus/register strobes. Strobes are combinational; step and halted are registered.
module control_sequencer #(
  parameter int unsigned STEPS     = 5,
  parameter bit          EARLY_END = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] instr,
  input  logic       cf,
  input  logic       zf,
  output logic       hlt,
  output logic       co,
  output logic       mi,
  output logic       ri,
  output logic       ro,
  output logic       io,
  output logic       ii,
  output logic       ai,
  output logic       ao,
  output logic       eo,
  output logic       su,
  output logic       bi,
  output logic       oi,
  output logic       ce,
  output logic       j,
  output logic       fi,
  output logic [2:0] step,
  output logic       halted
);

  typedef enum logic [3:0] {
    OpNop = 4'h0,
    OpLda = 4'h1,
    OpAdd = 4'h2,
    OpSub = 4'h3,
    OpSta = 4'h4,
    OpLdi = 4'h5,
    OpJmp = 4'h6,
    OpJc  = 4'h7,
    OpJz  = 4'h8,
    OpOut = 4'hE,
    OpHlt = 4'hF
  } opcode_e;

  opcode_e    op;
  logic       active;
  logic [2:0] last_step;

  assign op     = opcode_e'(instr);
  assign active = !clr && en && !halted;

  always_comb begin
    last_step = 3'd1;
    case (op)
      OpLdi, OpJmp, OpJc, OpJz, OpOut, OpHlt: last_step = 3'd2;
      OpLda, OpSta:                           last_step = 3'd3;
      OpAdd, OpSub:                           last_step = 3'd4;
      default:                                last_step = 3'd1;
    endcase
  end

  always_comb begin
    hlt = !clr && halted;
    co = 1'b0; mi = 1'b0; ri = 1'b0; ro = 1'b0; io = 1'b0; ii = 1'b0; ai = 1'b0;
    ao = 1'b0; eo = 1'b0; su = 1'b0; bi = 1'b0; oi = 1'b0; ce = 1'b0; j = 1'b0;
    fi = 1'b0;
    if (active) begin
      case (step)
        3'd0: begin co = 1'b1; mi = 1'b1; end
        3'd1: begin ro = 1'b1; ii = 1'b1; ce = 1'b1; end
        3'd2: begin
          case (op)
            OpLda, OpAdd, OpSub, OpSta: begin io = 1'b1; mi = 1'b1; end
            OpLdi: begin io = 1'b1; ai = 1'b1; end
            OpJmp: begin io = 1'b1; j = 1'b1; end
            OpJc:  begin io = cf; j = cf; end
            OpJz:  begin io = zf; j = zf; end
            OpOut: begin ao = 1'b1; oi = 1'b1; end
            OpHlt: hlt = 1'b1;
            default: ;
          endcase
        end
        3'd3: begin
          case (op)
            OpLda:        begin ro = 1'b1; ai = 1'b1; end
            OpAdd, OpSub: begin ro = 1'b1; bi = 1'b1; end
            OpSta:        begin ao = 1'b1; ri = 1'b1; end
            default: ;
          endcase
        end
        3'd4: begin
          case (op)
            OpAdd: begin eo = 1'b1; ai = 1'b1; fi = 1'b1; end
            OpSub: begin eo = 1'b1; su = 1'b1; ai = 1'b1; fi = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // instr still holds the previous opcode until IR loads at the end of T1,
  // so the early-end decision is only taken from T2 onward.
  always_ff @(posedge clk) begin
    if (clr) begin
      step   <= 3'd0;
      halted <= 1'b0;
    end else if (en && !halted) begin
      if (step == 3'd2 && op == OpHlt) begin
        halted <= 1'b1;
      end else if (EARLY_END && step >= 3'd2 && step >= last_step) begin
        step <= 3'd0;
      end else if (step == 3'(STEPS - 1)) begin
        step <= 3'd0;
      end else begin
        step <= step + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: table-driven microcode model checked every cycle on two
// instances (early end on and off), plus hand-computed literal expectations.
module tb_control_sequencer;

  localparam logic [15:0] H  = 16'h8000, CO = 16'h4000, MI = 16'h2000, RI = 16'h1000;
  localparam logic [15:0] RO = 16'h0800, IO = 16'h0400, II = 16'h0200, AI = 16'h0100;
  localparam logic [15:0] AO = 16'h0080, EO = 16'h0040, SU = 16'h0020, BI = 16'h0010;
  localparam logic [15:0] OI = 16'h0008, CE = 16'h0004, JJ = 16'h0002, FI = 16'h0001;
  localparam logic [15:0] BUS = CO | RO | IO | AO | EO;

  logic clk = 1'b0;
  logic clr, en, cf, zf;
  logic [3:0] instr;

  logic hlt1, co1, mi1, ri1, ro1, io1, ii1, ai1, ao1, eo1, su1, bi1, oi1, ce1, j1, fi1;
  logic hlt0, co0, mi0, ri0, ro0, io0, ii0, ai0, ao0, eo0, su0, bi0, oi0, ce0, j0, fi0;
  logic [2:0] step1, step0;
  logic halted1, halted0;
  logic [15:0] v1, v0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_sequencer #(.STEPS(5), .EARLY_END(1'b1)) dut1 (
    .clk(clk), .clr(clr), .en(en), .instr(instr), .cf(cf), .zf(zf),
    .hlt(hlt1), .co(co1), .mi(mi1), .ri(ri1), .ro(ro1), .io(io1), .ii(ii1), .ai(ai1),
    .ao(ao1), .eo(eo1), .su(su1), .bi(bi1), .oi(oi1), .ce(ce1), .j(j1), .fi(fi1),
    .step(step1), .halted(halted1)
  );

  control_sequencer #(.STEPS(5), .EARLY_END(1'b0)) dut0 (
    .clk(clk), .clr(clr), .en(en), .instr(instr), .cf(cf), .zf(zf),
    .hlt(hlt0), .co(co0), .mi(mi0), .ri(ri0), .ro(ro0), .io(io0), .ii(ii0), .ai(ai0),
    .ao(ao0), .eo(eo0), .su(su0), .bi(bi0), .oi(oi0), .ce(ce0), .j(j0), .fi(fi0),
    .step(step0), .halted(halted0)
  );

  assign v1 = {hlt1, co1, mi1, ri1, ro1, io1, ii1, ai1, ao1, eo1, su1, bi1, oi1, ce1, j1, fi1};
  assign v0 = {hlt0, co0, mi0, ri0, ro0, io0, ii0, ai0, ao0, eo0, su0, bi0, oi0, ce0, j0, fi0};

  // Microcode table: execute strobes for T2..T4 and the last active step per opcode.
  logic [15:0] ucode [16][3];
  int          last_s [16];
  int          m_step [2];
  bit          m_halted [2];

  initial begin
    for (int o = 0; o < 16; o++) begin
      for (int s = 0; s < 3; s++) ucode[o][s] = 16'h0;
      last_s[o] = 1;
    end
    ucode[1][0]  = IO | MI; ucode[1][1] = RO | AI;                          last_s[1]  = 3;
    ucode[2][0]  = IO | MI; ucode[2][1] = RO | BI; ucode[2][2] = EO | AI | FI; last_s[2]  = 4;
    ucode[3][0]  = IO | MI; ucode[3][1] = RO | BI;
    ucode[3][2]  = EO | SU | AI | FI;                                       last_s[3]  = 4;
    ucode[4][0]  = IO | MI; ucode[4][1] = AO | RI;                          last_s[4]  = 3;
    ucode[5][0]  = IO | AI;                                                 last_s[5]  = 2;
    ucode[6][0]  = IO | JJ;                                                 last_s[6]  = 2;
    ucode[7][0]  = IO | JJ;                                                 last_s[7]  = 2;
    ucode[8][0]  = IO | JJ;                                                 last_s[8]  = 2;
    ucode[14][0] = AO | OI;                                                 last_s[14] = 2;
    ucode[15][0] = H;                                                       last_s[15] = 2;
    m_step[0] = 0; m_step[1] = 0; m_halted[0] = 1'b0; m_halted[1] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_out(input int d);
    if (clr) return 16'h0;
    if (!en || m_halted[d]) return m_halted[d] ? H : 16'h0;
    if (m_step[d] == 0) return CO | MI;
    if (m_step[d] == 1) return RO | II | CE;
    if ((instr == 4'h7 && !cf) || (instr == 4'h8 && !zf)) return 16'h0;
    return ucode[instr][m_step[d] - 2];
  endfunction

  // Per-cycle compare against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [15:0] got;
      logic [2:0]  gstep;
      logic        ghalt;
      got   = (d == 1) ? v1 : v0;
      gstep = (d == 1) ? step1 : step0;
      ghalt = (d == 1) ? halted1 : halted0;
      chk($sformatf("model_strobes_ee%0d", d), 32'(got), 32'(m_out(d)));
      chk($sformatf("model_step_ee%0d", d), 32'(gstep), 32'(m_step[d]));
      chk($sformatf("model_halted_ee%0d", d), 32'(ghalt), 32'(m_halted[d]));
      chk($sformatf("bus_drivers_ee%0d", d), 32'($countones(got & BUS) > 1), 32'd0);
      if (clr) begin
        m_step[d] = 0;
        m_halted[d] = 1'b0;
      end else if (en && !m_halted[d]) begin
        if (m_step[d] == 2 && instr == 4'hF) m_halted[d] = 1'b1;
        else if (d == 1 && m_step[d] >= 2 && m_step[d] >= last_s[instr]) m_step[d] = 0;
        else if (m_step[d] == 4) m_step[d] = 0;
        else m_step[d] = m_step[d] + 1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic realign(input logic [3:0] op);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    instr = op;
    #1;
  endtask

  initial begin
    clr = 1'b1; en = 1'b1; instr = 4'h0; cf = 1'b0; zf = 1'b0;
    // Reset held two cycles with en=1
    cyc(); #1 chk("clr_strobes_a", 32'(v1), 32'h0);
    cyc(); #1 chk("clr_strobes_b", 32'(v1), 32'h0);
    // ADD sequence
    cyc(); clr = 1'b0; instr = 4'h2;
    #1 chk("rel_step0", 32'(step1), 32'd0);
    chk("t0_fetch", 32'(v1), 32'h6000);
    cyc(); #1 chk("t1_fetch", 32'(v1), 32'h0A04);
    cyc(); #1 chk("add_t2", 32'(v1), 32'h2400);
    cyc(); #1 chk("add_t3", 32'(v1), 32'h0810);
    cyc(); #1 chk("add_t4", 32'(v1), 32'h0141);
    cyc(); #1 chk("add_wrap", 32'(step1), 32'd0);
    // JC taken then not taken
    instr = 4'h7; cf = 1'b1;
    cyc(); cyc(); #1 chk("jc_taken_t2", 32'(v1), 32'h0402);
    cyc(); #1 chk("jc_taken_end", 32'(step1), 32'd0);
    cf = 1'b0;
    cyc(); cyc(); #1 chk("jc_not_t2", 32'(v1), 32'h0);
    cyc(); #1 chk("jc_not_end", 32'(step1), 32'd0);
    // HLT
    realign(4'hF);
    cyc(); cyc(); #1 chk("hlt_t2", 32'(v1), 32'h8000);
    cyc(); #1 chk("halted_set", 32'(halted1), 32'd1);
    chk("halted_step", 32'(step1), 32'd2);
    repeat (20) cyc();
    chk("halted_sticky", 32'(v1), 32'h8000);
    clr = 1'b1; #1 chk("clr_over_halt", 32'(v1), 32'h0);
    cyc(); clr = 1'b0; instr = 4'h1;
    #1 chk("halt_clr_t0", 32'(v1), 32'h6000);
    // LDA with en=0 during T3
    cyc(); cyc(); cyc(); en = 1'b0;
    #1 chk("lda_frz_strobes", 32'(v1), 32'h0);
    cyc(); #1 chk("lda_frz_step_a", 32'(step1), 32'd3);
    cyc(); #1 chk("lda_frz_step_b", 32'(step1), 32'd3);
    en = 1'b1;
    #1 chk("lda_resume_t3", 32'(v1), 32'h0900);
    cyc(); #1 chk("lda_end", 32'(step1), 32'd0);
    // Undefined opcode with early end disabled runs the full T0..T4
    realign(4'h9);
    cyc(); cyc(); cyc(); cyc(); #1 chk("undef_t4", 32'(step0), 32'd4);
    chk("undef_t4_idle", 32'(v0), 32'h0);
    cyc(); #1 chk("undef_wrap", 32'(step0), 32'd0);
    // Every opcode, random flags, random enable gaps, clr mid-instruction
    for (int op = 0; op < 16; op++) begin
      realign(4'(op));
      cf = 1'($urandom_range(0, 1));
      zf = 1'($urandom_range(0, 1));
      repeat (9) begin
        en = ($urandom_range(0, 3) != 0);
        cyc();
      end
      en = 1'b1;
      repeat (3) cyc();
    end
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
